// File: rtl/fb_fill_engine.sv
// Rectangle fill engine: a 4-register Avalon slave programs a constant-colour
// fill, issued as single-word Avalon master writes, one pixel per accepted transfer.
module fb_fill_engine #(
  parameter int STRIDE_BYTES = 2560
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  slave_address,
  input  logic        slave_read_en,
  input  logic        slave_write_en,
  output logic [31:0] slave_read_data,
  input  logic [31:0] slave_write_data,
  output logic [31:0] master_address,
  output logic        master_write,
  output logic [31:0] master_write_data,
  input  logic        master_wait_request
);
  localparam logic [31:0] STRIDE = 32'(STRIDE_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FINISH} state_t;

  state_t      state;
  logic [31:0] dest_r, size_r, color_r, row_addr;
  logic [15:0] x, y, w_lat, h_lat;
  logic        done, busy, start, ctrl_rd, accept;

  assign busy    = (state != S_IDLE);
  assign start   = slave_write_en && (slave_address == 2'd0) && slave_write_data[0];
  assign ctrl_rd = slave_read_en && (slave_address == 2'd0);
  assign accept  = master_write && !master_wait_request;

  always_comb begin
    slave_read_data = 32'd0;
    if (slave_read_en) begin
      case (slave_address)
        2'd0: slave_read_data = {30'd0, done, busy};
        2'd1: slave_read_data = dest_r;
        2'd2: slave_read_data = size_r;
        2'd3: slave_read_data = color_r;
        default: slave_read_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      dest_r            <= '0;
      size_r            <= '0;
      color_r           <= '0;
      row_addr          <= '0;
      x                 <= '0;
      y                 <= '0;
      w_lat             <= '0;
      h_lat             <= '0;
      done              <= 1'b0;
      master_write      <= 1'b0;
      master_address    <= '0;
      master_write_data <= '0;
    end else begin
      if (slave_write_en) begin
        case (slave_address)
          2'd1: dest_r  <= slave_write_data;
          2'd2: size_r  <= slave_write_data;
          2'd3: color_r <= slave_write_data;
          default: ;
        endcase
      end
      if (ctrl_rd) done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            done <= 1'b0;
            if (size_r[15:0] == 16'd0 || size_r[31:16] == 16'd0) begin
              state <= S_FINISH;
            end else begin
              w_lat             <= size_r[15:0];
              h_lat             <= size_r[31:16];
              row_addr          <= dest_r;
              master_address    <= dest_r;
              master_write_data <= color_r;
              master_write      <= 1'b1;
              x                 <= '0;
              y                 <= '0;
              state             <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (accept) begin
            if (x != w_lat - 16'd1) begin
              x              <= x + 16'd1;
              master_address <= master_address + 32'd4;
            end else if (y != h_lat - 16'd1) begin
              // next row starts from the row base, not from the last pixel
              x              <= '0;
              y              <= y + 16'd1;
              row_addr       <= row_addr + STRIDE;
              master_address <= row_addr + STRIDE;
            end else begin
              master_write <= 1'b0;
              state        <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_fill_engine.sv
// Bench for fb_fill_engine: table-driven fills, hand-written corner sequences,
// and random fills checked against a row/column address model.
module tb_fb_fill_engine;
  localparam int STRIDE = 2560;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  slave_address;
  logic        slave_read_en, slave_write_en;
  logic [31:0] slave_read_data, slave_write_data;
  logic [31:0] master_address, master_write_data;
  logic        master_write;
  logic        master_wait_request = 1'b0;

  fb_fill_engine #(.STRIDE_BYTES(STRIDE)) dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_read_en(slave_read_en),
    .slave_write_en(slave_write_en), .slave_read_data(slave_read_data),
    .slave_write_data(slave_write_data),
    .master_address(master_address), .master_write(master_write),
    .master_write_data(master_write_data), .master_wait_request(master_wait_request)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, stall_pct = 0;
  logic [31:0] got_addr[$], got_data[$];
  int          got_cyc[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    master_wait_request = (stall_pct != 0) && ($urandom_range(99) < stall_pct);
  end

  // Transfer monitor: logs accepted words and checks stalled words stay put.
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_write", {31'd0, master_write}, 32'd1);
      chk("hold_addr", master_address, prev_addr);
      chk("hold_data", master_write_data, prev_data);
    end
    prev_stall = master_write && master_wait_request;
    prev_addr  = master_address;
    prev_data  = master_write_data;
    if (master_write && !master_wait_request) begin
      got_addr.push_back(master_address);
      got_data.push_back(master_write_data);
      got_cyc.push_back(cyc);
    end
  end

  // All bus tasks are entered and left at posedge+1.
  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    slave_address = a; slave_write_data = d; slave_write_en = 1'b1;
    @(posedge clk); #1;
    slave_write_en = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    slave_address = a; slave_read_en = 1'b1;
    @(negedge clk); d = slave_read_data;
    @(posedge clk); #1;
    slave_read_en = 1'b0;
  endtask

  // Reads CTRL every cycle until it stops reporting busy; call right after the start write.
  task automatic poll(output int busy_n, output logic [31:0] last,
                      output logic fmw, output logic [31:0] faddr);
    slave_address = 2'd0; slave_read_en = 1'b1; busy_n = 0; last = 32'h1;
    fmw = 1'b0; faddr = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 0) begin fmw = master_write; faddr = master_address; end
      last = slave_read_data;
      if (last != 32'h1) break;
      busy_n++;
    end
    @(posedge clk); #1;
    slave_read_en = 1'b0;
  endtask

  task automatic clear_log();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
  endtask

  // Reference: pixel (xx,yy) lives at dest + yy*stride + xx*4, raster order, mod 2^32.
  task automatic verify(string tag, input logic [31:0] dest, input int w, input int h,
                        input logic [31:0] color);
    int n = w * h;
    int k = 0;
    logic [31:0] e;
    chk({tag, "_count"}, got_addr.size(), n);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        e = dest + 32'(yy) * 32'(STRIDE) + 32'(xx) * 32'd4;
        if (k < got_addr.size()) begin
          chk({tag, "_addr"}, got_addr[k], e);
          chk({tag, "_data"}, got_data[k], color);
        end
        k++;
      end
  endtask

  task automatic run_fill(string tag, input logic [31:0] dest, input int w, input int h,
                          input logic [31:0] color, input int stall);
    int busy_n;
    logic [31:0] last, faddr, rd;
    logic fmw;
    clear_log();
    stall_pct = stall;
    reg_wr(2'd1, dest);
    reg_wr(2'd2, {h[15:0], w[15:0]});
    reg_wr(2'd3, color);
    reg_wr(2'd0, 32'd1);
    poll(busy_n, last, fmw, faddr);
    stall_pct = 0;
    chk({tag, "_first_write"}, {31'd0, fmw}, 32'd1);
    chk({tag, "_first_addr"}, faddr, dest);
    chk({tag, "_done_read"}, last, 32'h2);
    if (stall == 0) begin
      chk({tag, "_busy_cycles"}, busy_n, w * h + 1);
      if (got_cyc.size() > 0)
        chk({tag, "_back_to_back"}, got_cyc[got_cyc.size()-1] - got_cyc[0], w * h - 1);
    end
    verify(tag, dest, w, h, color);
    reg_rd(2'd0, rd);
    chk({tag, "_done_cleared"}, rd, 32'h0);
  endtask

  typedef struct {
    logic [31:0] dest;
    int          w, h;
    logic [31:0] color;
    int          stall;
    int          exp_n;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int busy_n;
    logic [31:0] last, faddr, rd;
    logic fmw;
    int n;

    vecs[0] = '{32'h0000_1000, 4, 2, 32'hAABB_CCDD,  0, 8, 32'h0000_1A0C};
    vecs[1] = '{32'h0000_1000, 4, 2, 32'hAABB_CCDD, 50, 8, 32'h0000_1A0C};
    vecs[2] = '{32'hFFFF_FFFC, 2, 1, 32'h1234_5678,  0, 2, 32'h0000_0000};
    vecs[3] = '{32'h0000_0400, 1, 3, 32'h0F0F_0F0F, 30, 3, 32'h0000_1800};
    vecs[4] = '{32'h0000_0010, 3, 1, 32'hDEAD_BEEF,  0, 3, 32'h0000_0018};

    reset = 1'b1; slave_address = '0; slave_read_en = 1'b0;
    slave_write_en = 1'b0; slave_write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_master_write", {31'd0, master_write}, 32'd0);
    chk("rst_master_address", master_address, 32'd0);
    chk("rst_master_data", master_write_data, 32'd0);
    chk("rst_read_idle", slave_read_data, 32'd0);
    @(posedge clk); #1;
    for (int a = 0; a < 4; a++) begin
      reg_rd(a[1:0], rd);
      chk("rst_reg", rd, 32'd0);
    end

    foreach (vecs[i]) begin
      run_fill($sformatf("vec%0d", i), vecs[i].dest, vecs[i].w, vecs[i].h,
               vecs[i].color, vecs[i].stall);
      chk($sformatf("vec%0d_n", i), got_addr.size(), vecs[i].exp_n);
      if (got_addr.size() > 0)
        chk($sformatf("vec%0d_last", i), got_addr[got_addr.size()-1], vecs[i].exp_last);
    end

    // zero height, then zero width
    for (int z = 0; z < 2; z++) begin
      clear_log();
      reg_wr(2'd2, z == 0 ? 32'h0000_0005 : 32'h0003_0000);
      reg_wr(2'd0, 32'd1);
      poll(busy_n, last, fmw, faddr);
      chk("zero_busy_cycles", busy_n, 1);
      chk("zero_done", last, 32'h2);
      repeat (3) @(posedge clk); #1;
      chk("zero_writes", got_addr.size(), 0);
    end

    // DEST write and restart while busy only affect the next fill
    clear_log();
    reg_wr(2'd1, 32'h0000_1000);
    reg_wr(2'd2, 32'h0002_0004);
    reg_wr(2'd3, 32'h5566_7788);
    reg_wr(2'd0, 32'd1);
    reg_wr(2'd1, 32'h0000_2000);
    reg_wr(2'd0, 32'd1);
    poll(busy_n, last, fmw, faddr);
    chk("busy_wr_done", last, 32'h2);
    repeat (12) @(posedge clk); #1;
    verify("busy_wr_first", 32'h0000_1000, 4, 2, 32'h5566_7788);
    clear_log();
    reg_wr(2'd0, 32'd1);
    poll(busy_n, last, fmw, faddr);
    verify("busy_wr_second", 32'h0000_2000, 4, 2, 32'h5566_7788);

    // random fills
    for (int r = 0; r < 4; r++) begin
      run_fill($sformatf("rnd%0d", r), $urandom() & 32'hFFFF_FFFC,
               $urandom_range(5, 1), $urandom_range(4, 1), $urandom(),
               $urandom_range(60, 0));
    end

    // reset during a fill aborts it
    clear_log();
    reg_wr(2'd1, 32'h0000_3000);
    reg_wr(2'd2, 32'h0004_0008);
    reg_wr(2'd3, 32'h1111_2222);
    reg_wr(2'd0, 32'd1);
    repeat (4) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_write_low", {31'd0, master_write}, 32'd0);
    reset = 1'b0;
    n = got_addr.size();
    repeat (20) @(posedge clk); #1;
    chk("abort_no_writes", got_addr.size(), n);
    for (int a = 0; a < 4; a++) begin
      reg_rd(a[1:0], rd);
      chk("abort_reg", rd, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
